// File: rtl/mips_ctrl_pkg.sv
// Shared decode constants for the MIPS ID-stage control: opcodes, R-type functs,
// ALU encodings and the bit layout of the 12-bit EX control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_RTYPE = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h03;
  localparam logic [5:0] OP_SW    = 6'h04;

  localparam logic [10:0] FN_ADD = 11'h2A0;
  localparam logic [10:0] FN_SUB = 11'h2A2;
  localparam logic [10:0] FN_AND = 11'h2A4;
  localparam logic [10:0] FN_OR  = 11'h2A5;
  localparam logic [10:0] FN_MUL = 11'h2B2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_MUL = 3'b100
  } alu_op_e;

  localparam int CTRL_ALU_LO    = 0;
  localparam int CTRL_ALU_HI    = 2;
  localparam int CTRL_IMM_SEL   = 3;
  localparam int CTRL_MEM_READ  = 4;
  localparam int CTRL_MEM_WRITE = 5;
  localparam int CTRL_REG_WRITE = 6;
  localparam int CTRL_DST_LO    = 7;
  localparam int CTRL_DST_HI    = 11;

  function automatic logic [11:0] pack_ctrl(alu_op_e alu, logic imm_sel, logic mem_read,
                                            logic mem_write, logic reg_write, logic [4:0] dst);
    return {dst, reg_write, mem_write, mem_read, imm_sel, alu};
  endfunction

endpackage

// File: rtl/mips_hazard_unit.sv
// Load-use hazard detector: requests a stall when the load now in EX writes a
// register the instruction in ID is about to read.
module mips_hazard_unit (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dst,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       reads_rt,
  output logic       stall
);

  assign stall = ex_mem_read & ((ex_dst == rs) | (reads_rt & (ex_dst == rt)));

endmodule

// File: rtl/mips_control.sv
// ID-stage decoder and ID/EX control register of the MIPS-like pipeline.
// Optional load-use stall logic is built when HAZARD_DETECT_EN is defined.
module mips_control
  import mips_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic [4:0]  a_reg,
  output logic [4:0]  b_reg,
  output logic [11:0] ctrl_ex,
  output logic        stall,
  output logic        illegal
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [10:0] funct;
  logic [11:0] ctrl_p0;
  logic        ill_p0;

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[10:0];

  assign a_reg = rs;
  assign b_reg = rt;

  // Stage p0: combinational decode of the instruction in ID
  always_comb begin
    ctrl_p0 = '0;
    ill_p0  = 1'b0;
    case (op)
      OP_NOP: ctrl_p0 = '0;
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  ctrl_p0 = pack_ctrl(ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b1, rd);
          FN_SUB:  ctrl_p0 = pack_ctrl(ALU_SUB, 1'b0, 1'b0, 1'b0, 1'b1, rd);
          FN_AND:  ctrl_p0 = pack_ctrl(ALU_AND, 1'b0, 1'b0, 1'b0, 1'b1, rd);
          FN_OR:   ctrl_p0 = pack_ctrl(ALU_OR,  1'b0, 1'b0, 1'b0, 1'b1, rd);
          FN_MUL:  ctrl_p0 = pack_ctrl(ALU_MUL, 1'b0, 1'b0, 1'b0, 1'b1, rd);
          default: ill_p0  = 1'b1;
        endcase
      end
      OP_LW:   ctrl_p0 = pack_ctrl(ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, rt);
      OP_SW:   ctrl_p0 = pack_ctrl(ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
      default: ill_p0  = 1'b1;
    endcase
  end

`ifdef HAZARD_DETECT_EN
  logic reads_rt;

  // Loads only read rs; R-type and stores also read rt.
  assign reads_rt = (op == OP_RTYPE) | (op == OP_SW);

  mips_hazard_unit u_hazard (
    .ex_mem_read (ctrl_ex[CTRL_MEM_READ]),
    .ex_dst      (ctrl_ex[CTRL_DST_HI:CTRL_DST_LO]),
    .rs          (rs),
    .rt          (rt),
    .reads_rt    (reads_rt),
    .stall       (stall)
  );
`else
  assign stall = 1'b0;
`endif

  // Stage p1: ID/EX register; a stall inserts a bubble while fetch holds instr
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_ex <= '0;
      illegal <= 1'b0;
    end else if (stall) begin
      ctrl_ex <= '0;
      illegal <= 1'b0;
    end else begin
      ctrl_ex <= ctrl_p0;
      illegal <= ill_p0;
    end
  end

endmodule

// File: tb/tb_mips_control.sv
// Randomized bench for mips_control with a behavioural decode/stall model and
// a few hand-computed instruction expectations.
module tb_mips_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [4:0]  a_reg;
  logic [4:0]  b_reg;
  logic [11:0] ctrl_ex;
  logic        stall;
  logic        illegal;

  int checks = 0;
  int errors = 0;

`ifdef HAZARD_DETECT_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  always #5 clk = ~clk;

  mips_control dut (
    .clk     (clk),
    .rst     (rst),
    .instr   (instr),
    .a_reg   (a_reg),
    .b_reg   (b_reg),
    .ctrl_ex (ctrl_ex),
    .stall   (stall),
    .illegal (illegal)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what sits in EX, described as "is it a load, and where does it write"
  logic [11:0] m_ctrl = '0;
  logic        m_ill = 1'b0;
  bit          m_ex_load = 1'b0;
  logic [4:0]  m_ex_dst = '0;
  bit          m_ok = 1'b0;

  function automatic logic [12:0] ref_decode(logic [31:0] in);
    int op, rs, rt, rd, fn, alu, v;
    op = int'(in[31:26]); rt = int'(in[20:16]); rd = int'(in[15:11]); fn = int'(in[10:0]);
    rs = int'(in[25:21]);
    if (op == 0) return 13'h0;
    if (op == 3) return 13'(8 + 16 + 64 + 128 * rt);
    if (op == 4) return 13'(8 + 32);
    if (op != 2) return 13'h1000;
    case (fn)
      'h2A0: alu = 0;
      'h2A2: alu = 1;
      'h2A4: alu = 2;
      'h2A5: alu = 3;
      'h2B2: alu = 4;
      default: alu = -1;
    endcase
    if (alu < 0) return 13'h1000;
    v = alu + 64 + 128 * rd;
    return 13'(v + 0 * rs);
  endfunction

  function automatic bit ref_stall(logic [31:0] in);
    bit reads_rt;
    if (!HAZ) return 1'b0;
    reads_rt = (in[31:26] == 6'd2) || (in[31:26] == 6'd4);
    return m_ex_load && ((m_ex_dst == in[25:21]) || (reads_rt && (m_ex_dst == in[20:16])));
  endfunction

  always @(posedge clk) begin
    logic [12:0] d;
    bit          st;
    st = ref_stall(instr);
    if (rst || st) begin
      m_ctrl    = '0;
      m_ill     = 1'b0;
      m_ex_load = 1'b0;
    end else begin
      d         = ref_decode(instr);
      m_ctrl    = d[11:0];
      m_ill     = d[12];
      m_ex_load = (instr[31:26] == 6'd3);
      m_ex_dst  = instr[20:16];
    end
    if (rst) m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("a_reg",   32'(a_reg),   32'(instr[25:21]));
      chk("b_reg",   32'(b_reg),   32'(instr[20:16]));
      chk("stall",   32'(stall),   32'(ref_stall(instr)));
      chk("ctrl_ex", 32'(ctrl_ex), 32'(m_ctrl));
      chk("illegal", 32'(illegal), 32'(m_ill));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [10:0] fn;
    logic [15:0] lo;
    int sel;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 4))
      0: fn = 11'h2A0;
      1: fn = 11'h2A2;
      2: fn = 11'h2A4;
      3: fn = 11'h2A5;
      default: fn = 11'h2B2;
    endcase
    lo = {rd, fn};
    sel = int'($urandom_range(0, 9));
    case (sel)
      0, 1, 2: op = 6'd2;
      3, 4: begin op = 6'd3; lo = 16'($urandom); end
      5, 6: begin op = 6'd4; lo = 16'($urandom); end
      7: op = 6'd0;
      8: op = 6'($urandom);
      default: begin op = 6'd2; lo = 16'($urandom); end
    endcase
    return {op, rs, rt, lo};
  endfunction

  localparam int NDIR = 11;
  localparam logic [31:0] T_IN [NDIR] = '{
    32'h0000_0000, 32'h0FE0_0001, 32'h0FE1_0002, 32'h0000_0000, 32'h0801_22B2,
    32'h0864_2AA0, 32'h0885_32A2, 32'h0821_0AA5, 32'h13E6_DFFF, 32'hFC00_0000,
    32'h0801_22A7};
  localparam logic [11:0] T_CTRL [NDIR] = '{
    12'h000, 12'h058, 12'h0D8, 12'h000, 12'h244,
    12'h2C0, 12'h341, 12'h0C3, 12'h028, 12'h000, 12'h000};
  localparam logic T_ILL [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                    1'b1, 1'b1};
  localparam logic [4:0] T_A [NDIR] = '{5'd0, 5'd31, 5'd31, 5'd0, 5'd0, 5'd3, 5'd4, 5'd1,
                                        5'd31, 5'd0, 5'd0};
  localparam logic [4:0] T_B [NDIR] = '{5'd0, 5'd0, 5'd1, 5'd0, 5'd1, 5'd4, 5'd5, 5'd1,
                                        5'd6, 5'd0, 5'd1};

  initial begin
    rst   = 1'b1;
    instr = 32'h0FE1_0002;
    tick();
    chk("reset_ctrl", 32'(ctrl_ex), 32'h000);
    chk("reset_ill",  32'(illegal), 32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < NDIR; i++) begin
      instr = T_IN[i];
      #1;
      chk($sformatf("dir%0d_a", i), 32'(a_reg), 32'(T_A[i]));
      chk($sformatf("dir%0d_b", i), 32'(b_reg), 32'(T_B[i]));
      tick();
      chk($sformatf("dir%0d_ctrl", i), 32'(ctrl_ex), 32'(T_CTRL[i]));
      chk($sformatf("dir%0d_ill", i),  32'(illegal), 32'(T_ILL[i]));
    end

    // lw r0 then lw r1,2(r31): rt of a load is not a source
    instr = 32'h0FE0_0001;
    tick();
    instr = 32'h0FE1_0002;
    #1;
    chk("lw_lw_stall", 32'(stall), 32'h0);
    tick();
    chk("lw_lw_ctrl", 32'(ctrl_ex), 32'h0D8);

    // lw r1 then mul r4,r0,r1 held by fetch
    instr = 32'h0FE1_0002;
    tick();
    instr = 32'h0801_22B2;
    #1;
    chk("lu_stall1", 32'(stall), HAZ ? 32'h1 : 32'h0);
    if (HAZ) begin
      tick();
      chk("lu_bubble", 32'(ctrl_ex), 32'h000);
      chk("lu_stall0", 32'(stall), 32'h0);
    end
    tick();
    chk("lu_mul", 32'(ctrl_ex), 32'h244);

    // Reset while a stall is pending, then normal decode resumes
    instr = 32'h0FE1_0002;
    tick();
    instr = 32'h0801_22B2;
    rst   = 1'b1;
    tick();
    chk("rst_stall_ctrl", 32'(ctrl_ex), 32'h000);
    chk("rst_stall_ill",  32'(illegal), 32'h0);
    rst = 1'b0;
    tick();
    chk("rst_resume", 32'(ctrl_ex), 32'h244);

    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      if (!ref_stall(instr)) instr = rand_instr();
      tick();
    end
    rst = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
